// File: rtl/fu_rdy_ctl_if.sv
// Issue-select to execute handshake bundle for the function-unit ready tracker.
// Latency: none (wires only); the tracker registers everything it drives.
// Backpressure: the ready vector is the only backpressure; issue strobes carry no handshake of their own.
interface fu_rdy_ctl_if;
    logic       mul_iss_vld;
    logic       alu1_iss_vld;
    logic       alu2_iss_vld;
    logic       adr_iss_vld;
    logic       exe_stall;
    logic       dmem_stall;
    logic       flush;
    logic [3:0] fun_rdy_frm_exe;
    logic       mul_done;
    logic       iss_err;

    // Issue-select side: produces strobes and stalls, consumes the ready vector.
    modport master (
        output mul_iss_vld, alu1_iss_vld, alu2_iss_vld, adr_iss_vld,
        output exe_stall, dmem_stall, flush,
        input  fun_rdy_frm_exe, mul_done, iss_err
    );

    // Tracker side.
    modport slave (
        input  mul_iss_vld, alu1_iss_vld, alu2_iss_vld, adr_iss_vld,
        input  exe_stall, dmem_stall, flush,
        output fun_rdy_frm_exe, mul_done, iss_err
    );
endinterface

// File: rtl/fu_rdy_ctl.sv
// Function-unit occupancy tracker: ready vector for MULT/ADD1/ADD2/ADDR, multiply-done pulse, sticky issue error.
// Latency: every output is a register; issue at t drops ready at t+1, mul_done at t+MUL_LAT.
// Backpressure: ready bit low means the unit must not issue; a violating issue is dropped and flagged.
// Optional FU_RDY_PERF_EN builds saturating per-unit accepted-issue counters on perf_cnt_flat.
module fu_rdy_ctl #(
    parameter int MUL_LAT   = 4,
    parameter int CNT_WIDTH = 4
`ifdef FU_RDY_PERF_EN
    ,
    parameter int PERF_WIDTH = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    fu_rdy_ctl_if.slave bus
`ifdef FU_RDY_PERF_EN
    ,
    output logic [4*PERF_WIDTH-1:0] perf_cnt_flat
`endif
);

    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;
    typedef enum logic [1:0] {A_IDLE, A_BUSY, A_WAIT} adr_state_t;

    // Counter is loaded with MUL_LAT-2 so that BUSY lasts MUL_LAT-1 cycles.
    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_LAT - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    mul_state_t           mul_state;
    logic [CNT_WIDTH-1:0] mul_cnt;
    logic                 mul_rdy;
    logic                 mul_done;
    adr_state_t           adr_state;
    logic                 adr_rdy;
    logic                 alu_hold;
    logic                 iss_err;
    logic [3:0]           fun_rdy;
    logic [3:0]           iss_vec;

    assign fun_rdy = {adr_rdy, ~alu_hold, ~alu_hold, mul_rdy};
    assign iss_vec = {bus.adr_iss_vld, bus.alu2_iss_vld, bus.alu1_iss_vld, bus.mul_iss_vld};

    assign bus.fun_rdy_frm_exe = fun_rdy;
    assign bus.mul_done        = mul_done;
    assign bus.iss_err         = iss_err;

    // Multiplier occupancy FSM; flush aborts the in-flight multiply without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state <= M_IDLE;
            mul_cnt   <= '0;
            mul_rdy   <= 1'b1;
            mul_done  <= 1'b0;
        end else if (bus.flush) begin
            mul_state <= M_IDLE;
            mul_cnt   <= '0;
            mul_rdy   <= 1'b1;
            mul_done  <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            case (mul_state)
                M_IDLE: begin
                    if (bus.mul_iss_vld) begin
                        mul_state <= M_BUSY;
                        mul_cnt   <= MUL_LOAD;
                        mul_rdy   <= 1'b0;
                    end
                end
                M_BUSY: begin
                    // Issues seen here are illegal and leave the countdown untouched.
                    if (mul_cnt == '0) begin
                        mul_state <= M_DONE;
                        mul_rdy   <= 1'b1;
                        mul_done  <= 1'b1;
                    end else begin
                        mul_cnt <= mul_cnt - CNT_ONE;
                    end
                end
                M_DONE: begin
                    // Back-to-back issue in the done cycle restarts without a bubble.
                    if (bus.mul_iss_vld) begin
                        mul_state <= M_BUSY;
                        mul_cnt   <= MUL_LOAD;
                        mul_rdy   <= 1'b0;
                    end else begin
                        mul_state <= M_IDLE;
                        mul_rdy   <= 1'b1;
                    end
                end
                default: begin
                    mul_state <= M_IDLE;
                    mul_cnt   <= '0;
                    mul_rdy   <= 1'b1;
                end
            endcase
        end
    end

    // Address-unit FSM: one busy cycle, then held for as long as data memory stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_state <= A_IDLE;
            adr_rdy   <= 1'b1;
        end else begin
            case (adr_state)
                A_IDLE: begin
                    if (bus.adr_iss_vld) begin
                        adr_state <= A_BUSY;
                        adr_rdy   <= 1'b0;
                    end
                end
                A_BUSY: begin
                    if (bus.dmem_stall) begin
                        adr_state <= A_WAIT;
                    end else begin
                        adr_state <= A_IDLE;
                        adr_rdy   <= 1'b1;
                    end
                end
                A_WAIT: begin
                    if (!bus.dmem_stall) begin
                        adr_state <= A_IDLE;
                        adr_rdy   <= 1'b1;
                    end
                end
                default: begin
                    adr_state <= A_IDLE;
                    adr_rdy   <= 1'b1;
                end
            endcase
        end
    end

    // Adders are fully pipelined; only a stalled execute stage withholds them, one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_hold <= 1'b0;
        end else begin
            alu_hold <= bus.exe_stall;
        end
    end

    // Sticky flag for any issue against a registered not-ready bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_err <= 1'b0;
        end else if ((iss_vec & ~fun_rdy) != 4'b0000) begin
            iss_err <= 1'b1;
        end
    end

`ifdef FU_RDY_PERF_EN
    logic [PERF_WIDTH-1:0] perf_cnt [4];
    logic [3:0]            perf_acc;

    // A flushed multiply issue is dropped, so it is not counted.
    assign perf_acc = iss_vec & fun_rdy & {3'b111, ~bus.flush};

    assign perf_cnt_flat = {perf_cnt[3], perf_cnt[2], perf_cnt[1], perf_cnt[0]};

    // Saturating accepted-issue counters, one per unit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                perf_cnt[i] <= '0;
            end else if (perf_acc[i] && (perf_cnt[i] != '1)) begin
                perf_cnt[i] <= perf_cnt[i] + PERF_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_rdy_ctl.sv
// Bench for fu_rdy_ctl: directed scenarios followed by random traffic against a cycle-count reference model.
// Latency: outputs are compared 1 time unit after every rising edge.
// Backpressure: the random driver deliberately issues into not-ready units to exercise the error path.
module tb_fu_rdy_ctl;
    localparam int MUL_LAT = 4;
    localparam int PW      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fu_rdy_ctl_if bus();

`ifdef FU_RDY_PERF_EN
    logic [4*PW-1:0] perf_cnt_flat;
`endif

    fu_rdy_ctl #(
        .MUL_LAT  (MUL_LAT),
        .CNT_WIDTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FU_RDY_PERF_EN
        ,
        .perf_cnt_flat(perf_cnt_flat)
`endif
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: multiplier tracked by the absolute cycle it frees up and the cycle it reports done.
    int         cyc        = 0;
    int         busy_until = 0;
    int         done_cyc   = -1;
    bit         hold_m     = 1'b0;
    bit         adr_busy   = 1'b0;
    bit         err_m      = 1'b0;
    int         cnt_m [4]  = '{0, 0, 0, 0};
    logic [3:0] exp_rdy    = 4'hF;
    logic       exp_done   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] iss;
        logic [3:0] acc;
        iss = {bus.adr_iss_vld, bus.alu2_iss_vld, bus.alu1_iss_vld, bus.mul_iss_vld};
        if (rst) begin
            busy_until = 0;
            done_cyc   = -1;
            hold_m     = 1'b0;
            adr_busy   = 1'b0;
            err_m      = 1'b0;
            for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        end else begin
            if ((iss & ~exp_rdy) != 4'b0000) err_m = 1'b1;
            acc = iss & exp_rdy;
            if (bus.flush) begin
                acc[0]     = 1'b0;
                busy_until = 0;
                done_cyc   = -1;
            end else if (acc[0]) begin
                busy_until = cyc + MUL_LAT;
                done_cyc   = cyc + MUL_LAT;
            end
            hold_m = bus.exe_stall;
            if (acc[3]) adr_busy = 1'b1;
            else if (adr_busy && !bus.dmem_stall) adr_busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && cnt_m[i] < 65535) cnt_m[i]++;
            end
        end
        cyc++;
        exp_rdy  = {!adr_busy, !hold_m, !hold_m, (cyc >= busy_until)};
        exp_done = (cyc == done_cyc);
    endtask

    task automatic tick();
        logic [63:0] pe;
        @(posedge clk);
        model_edge();
        #1;
        chk("rdy_vec", {60'd0, bus.fun_rdy_frm_exe}, {60'd0, exp_rdy});
        chk("mul_done", {63'd0, bus.mul_done}, {63'd0, exp_done});
        chk("iss_err", {63'd0, bus.iss_err}, {63'd0, err_m});
`ifdef FU_RDY_PERF_EN
        pe = {cnt_m[3][15:0], cnt_m[2][15:0], cnt_m[1][15:0], cnt_m[0][15:0]};
        chk("perf_cnt", perf_cnt_flat, pe);
`else
        pe = '0;
`endif
    endtask

    task automatic idle_inputs();
        bus.mul_iss_vld  = 1'b0;
        bus.alu1_iss_vld = 1'b0;
        bus.alu2_iss_vld = 1'b0;
        bus.adr_iss_vld  = 1'b0;
        bus.exe_stall    = 1'b0;
        bus.dmem_stall   = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // Reset, then three idle cycles.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("t1_rdy", {60'd0, bus.fun_rdy_frm_exe}, 64'hF);
        chk("t1_done", {63'd0, bus.mul_done}, 64'd0);
        chk("t1_err", {63'd0, bus.iss_err}, 64'd0);

        // Multiply at t=0, reissue in the done cycle t=4.
        bus.mul_iss_vld = 1'b1;
        tick();
        bus.mul_iss_vld = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            chk("t2_busy", {63'd0, bus.fun_rdy_frm_exe[0]}, 64'd0);
            tick();
        end
        chk("t2_done4", {63'd0, bus.mul_done}, 64'd1);
        chk("t2_rdy4", {63'd0, bus.fun_rdy_frm_exe[0]}, 64'd1);
        bus.mul_iss_vld = 1'b1;
        tick();
        bus.mul_iss_vld = 1'b0;
        chk("t2_busy5", {63'd0, bus.fun_rdy_frm_exe[0]}, 64'd0);
        for (int t = 6; t <= 8; t++) tick();
        chk("t2_done8", {63'd0, bus.mul_done}, 64'd1);
        tick();
        chk("t2_done9", {63'd0, bus.mul_done}, 64'd0);

        // Multiply at t=0 aborted by flush at t=2.
        bus.mul_iss_vld = 1'b1;
        tick();
        bus.mul_iss_vld = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t3_rdy3", {63'd0, bus.fun_rdy_frm_exe[0]}, 64'd1);
        for (int t = 4; t <= 10; t++) begin
            tick();
            chk("t3_nodone", {63'd0, bus.mul_done}, 64'd0);
        end

        // Address issue at t=0 with data memory stalled t=1..3.
        bus.adr_iss_vld = 1'b1;
        tick();
        bus.adr_iss_vld = 1'b0;
        bus.dmem_stall  = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            chk("t4_busy", {63'd0, bus.fun_rdy_frm_exe[3]}, 64'd0);
            tick();
        end
        bus.dmem_stall = 1'b0;
        chk("t4_busy4", {63'd0, bus.fun_rdy_frm_exe[3]}, 64'd0);
        tick();
        chk("t4_free5", {63'd0, bus.fun_rdy_frm_exe[3]}, 64'd1);

        // Execute stall at t=0..1 holds both adders only.
        bus.exe_stall = 1'b1;
        tick();
        chk("t5_hold1", {60'd0, bus.fun_rdy_frm_exe}, 64'h9);
        tick();
        bus.exe_stall = 1'b0;
        chk("t5_hold2", {60'd0, bus.fun_rdy_frm_exe}, 64'h9);
        tick();
        chk("t5_free3", {60'd0, bus.fun_rdy_frm_exe}, 64'hF);

        // Illegal multiply reissue at t=2 after a fresh reset.
        do_reset();
        bus.mul_iss_vld = 1'b1;
        tick();
        bus.mul_iss_vld = 1'b0;
        tick();
        bus.mul_iss_vld = 1'b1;
        tick();
        bus.mul_iss_vld = 1'b0;
        chk("t6_err3", {63'd0, bus.iss_err}, 64'd1);
        chk("t6_busy3", {63'd0, bus.fun_rdy_frm_exe[0]}, 64'd0);
        tick();
        chk("t6_done4", {63'd0, bus.mul_done}, 64'd1);
        for (int t = 5; t <= 8; t++) tick();
        chk("t6_sticky", {63'd0, bus.iss_err}, 64'd1);
        chk("t6_nodone8", {63'd0, bus.mul_done}, 64'd0);
`ifdef FU_RDY_PERF_EN
        chk("t6_perf_mul", {48'd0, perf_cnt_flat[15:0]}, 64'd1);
`endif

        // Random traffic including illegal issues, flushes, stalls and occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 79) == 0);
            bus.mul_iss_vld  = ($urandom_range(0, 2) == 0);
            bus.alu1_iss_vld = $urandom_range(0, 1) != 0;
            bus.alu2_iss_vld = $urandom_range(0, 1) != 0;
            bus.adr_iss_vld  = ($urandom_range(0, 2) == 0);
            bus.exe_stall    = ($urandom_range(0, 3) == 0);
            bus.dmem_stall   = $urandom_range(0, 1) != 0;
            bus.flush        = ($urandom_range(0, 11) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
